// File: rtl/seg_scan_decoder.sv
// Recovers two 16-bit values from a multiplexed, active-low 7-segment scan (8 digits).
// Optional partial-frame scan timeout is enabled by defining SCAN_TIMEOUT_EN.
module seg_scan_decoder #(
    parameter int unsigned STABLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [6:0]  out7,
    input  logic [7:0]  en_out,
    output logic [15:0] NumberA,
    output logic [15:0] NumberB,
    output logic        frame_valid,
    output logic        seg_err,
    output logic        stale
);

    localparam logic [7:0] StableMax = 8'(STABLE_CYCLES);

    if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255) begin : g_badStable
        $error("seg_scan_decoder: STABLE_CYCLES must be in 2..255");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_badTimeout
        $error("seg_scan_decoder: TIMEOUT_CYCLES must be at least 1");
    end

    logic [6:0]  segMeta_q, segSync_q;
    logic [7:0]  enMeta_q, enSync_q;
    logic [14:0] prev_q;
    logic [7:0]  stableCnt_q, stableCnt_d;
    logic [31:0] shadow_q, shadow_d;
    logic [7:0]  seen_q, seen_d;
    logic [15:0] numA_q, numA_d, numB_q, numB_d;
    logic        frameValid_q, frameValid_d;
    logic        segErr_q, segErr_d;

    logic        legalSel;
    logic [2:0]  digitIdx;
    logic        capture;
    logic        glyphOk;
    logic [3:0]  glyphVal;
    logic        validCapture;
    logic        timeoutHit;

    // Active-low {a..g} glyph to {recognised, nibble}.
    function automatic logic [4:0] decodeGlyph(input logic [6:0] g);
        case (g)
            7'h01:   return {1'b1, 4'h0};
            7'h4F:   return {1'b1, 4'h1};
            7'h12:   return {1'b1, 4'h2};
            7'h06:   return {1'b1, 4'h3};
            7'h4C:   return {1'b1, 4'h4};
            7'h24:   return {1'b1, 4'h5};
            7'h20:   return {1'b1, 4'h6};
            7'h0F:   return {1'b1, 4'h7};
            7'h00:   return {1'b1, 4'h8};
            7'h04:   return {1'b1, 4'h9};
            7'h08:   return {1'b1, 4'hA};
            7'h60:   return {1'b1, 4'hB};
            7'h31:   return {1'b1, 4'hC};
            7'h42:   return {1'b1, 4'hD};
            7'h30:   return {1'b1, 4'hE};
            7'h38:   return {1'b1, 4'hF};
            default: return 5'b0_0000;
        endcase
    endfunction

    always_comb begin
        legalSel = 1'b0;
        digitIdx = '0;
        for (int i = 0; i < 8; i++) begin
            if (enSync_q == ~(8'd1 << i)) begin
                legalSel = 1'b1;
                digitIdx = 3'(i);
            end
        end
    end

    // The counter saturates at StableMax, so capture fires only on the entering edge.
    always_comb begin
        if (!legalSel) begin
            stableCnt_d = '0;
        end else if ({enSync_q, segSync_q} == prev_q) begin
            stableCnt_d = (stableCnt_q == StableMax) ? stableCnt_q : stableCnt_q + 8'd1;
        end else begin
            stableCnt_d = 8'd1;
        end
        capture = legalSel && (stableCnt_d == StableMax) && (stableCnt_q != StableMax);
    end

    assign {glyphOk, glyphVal} = decodeGlyph(segSync_q);
    assign validCapture = capture && glyphOk;

    // A capture landing on the frame-completion edge belongs to the next frame.
    always_comb begin
        seen_d       = seen_q;
        shadow_d     = shadow_q;
        numA_d       = numA_q;
        numB_d       = numB_q;
        frameValid_d = 1'b0;
        segErr_d     = 1'b0;
        if (seen_q == 8'hFF) begin
            numA_d       = shadow_q[31:16];
            numB_d       = shadow_q[15:0];
            frameValid_d = 1'b1;
            seen_d       = '0;
        end else if (timeoutHit) begin
            seen_d = '0;
        end
        if (capture) begin
            if (glyphOk) begin
                shadow_d[{digitIdx, 2'b00} +: 4] = glyphVal;
                seen_d[digitIdx]                 = 1'b1;
            end else begin
                segErr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            segMeta_q    <= '1;
            segSync_q    <= '1;
            enMeta_q     <= '1;
            enSync_q     <= '1;
            prev_q       <= '1;
            stableCnt_q  <= '0;
            shadow_q     <= '0;
            seen_q       <= '0;
            numA_q       <= '0;
            numB_q       <= '0;
            frameValid_q <= 1'b0;
            segErr_q     <= 1'b0;
        end else begin
            segMeta_q    <= out7;
            segSync_q    <= segMeta_q;
            enMeta_q     <= en_out;
            enSync_q     <= enMeta_q;
            prev_q       <= {enSync_q, segSync_q};
            stableCnt_q  <= stableCnt_d;
            shadow_q     <= shadow_d;
            seen_q       <= seen_d;
            numA_q       <= numA_d;
            numB_q       <= numB_d;
            frameValid_q <= frameValid_d;
            segErr_q     <= segErr_d;
        end
    end

`ifdef SCAN_TIMEOUT_EN
    localparam int IdleW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IdleW-1:0] IdleLimit = IdleW'(TIMEOUT_CYCLES);

    logic [IdleW-1:0] idle_q, idle_d;
    logic             stale_q, stale_d;

    // Idle time is only tracked while a partial frame is pending.
    always_comb begin
        idle_d = '0;
        if (!validCapture && (seen_q != 8'h00)) begin
            idle_d = idle_q + 1'b1;
        end
        timeoutHit = (seen_q != 8'h00) && (seen_q != 8'hFF) && (idle_d == IdleLimit);
        stale_d    = stale_q;
        if (seen_q == 8'hFF) begin
            stale_d = 1'b0;
        end else if (timeoutHit) begin
            stale_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            idle_q  <= '0;
            stale_q <= 1'b0;
        end else begin
            idle_q  <= idle_d;
            stale_q <= stale_d;
        end
    end

    assign stale = stale_q;
`else
    assign timeoutHit = 1'b0;
    assign stale      = 1'b0;
`endif

    assign NumberA     = numA_q;
    assign NumberB     = numB_q;
    assign frame_valid = frameValid_q;
    assign seg_err     = segErr_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed scans plus randomized segments
// checked against a run-length behavioural model of the scan capture rules.
module tb_seg_scan_decoder;

    localparam int S = 16;
    localparam int T = 1000;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [6:0]  out7 = 7'h7F;
    logic [7:0]  en_out = 8'hFF;
    logic [15:0] NumberA, NumberB;
    logic        frame_valid, seg_err, stale;

    seg_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .Clk(Clk), .Reset(Reset), .out7(out7), .en_out(en_out),
        .NumberA(NumberA), .NumberB(NumberB),
        .frame_valid(frame_valid), .seg_err(seg_err), .stale(stale)
    );

    always #5 Clk = ~Clk;

    int vectors = 0;
    int miscompares = 0;

    logic [6:0] glyphTab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                  7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    // Reference model state: run-length of the raw input plus the frame being assembled.
    logic [14:0] runVal = 15'h7FFF;
    int          runLen = 0;
    logic [3:0]  shadowM [8];
    logic [7:0]  seenM = 8'h00;
    int          expFrames = 0;
    int          expErrs = 0;
    logic [15:0] expA = 16'h0;
    logic [15:0] expB = 16'h0;
    logic        expStale = 1'b0;
    int          idleM = 0;

    int          fvCount = 0;
    int          errCount = 0;
    logic [15:0] lastA = 16'h0;
    logic [15:0] lastB = 16'h0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int glyphToVal(input logic [6:0] g);
        for (int i = 0; i < 16; i++) begin
            if (glyphTab[i] == g) return i;
        end
        return -1;
    endfunction

    task automatic modelCycle(input logic [7:0] en, input logic [6:0] seg);
        bit validCap;
        int d;
        int v;
        validCap = 0;
        if ({en, seg} == runVal) begin
            runLen++;
        end else begin
            runVal = {en, seg};
            runLen = 1;
        end
        if ($countones(~en) == 1 && runLen == S) begin
            d = 0;
            for (int i = 0; i < 8; i++) if (!en[i]) d = i;
            v = glyphToVal(seg);
            if (v < 0) begin
                expErrs++;
            end else begin
                validCap = 1;
                shadowM[d] = 4'(v);
                seenM[d] = 1'b1;
                if (seenM == 8'hFF) begin
                    expFrames++;
                    expA = {shadowM[7], shadowM[6], shadowM[5], shadowM[4]};
                    expB = {shadowM[3], shadowM[2], shadowM[1], shadowM[0]};
                    seenM = 8'h00;
                    expStale = 1'b0;
                end
            end
        end
`ifdef SCAN_TIMEOUT_EN
        if (validCap) begin
            idleM = 0;
        end else if (seenM != 8'h00) begin
            idleM++;
            if (idleM == T) begin
                seenM = 8'h00;
                expStale = 1'b1;
                idleM = 0;
            end
        end else begin
            idleM = 0;
        end
`endif
    endtask

    task automatic applyStimulus(input logic [7:0] en, input logic [6:0] seg, input int n);
        for (int k = 0; k < n; k++) begin
            en_out = en;
            out7 = seg;
            modelCycle(en, seg);
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic scanFrame(input logic [15:0] a, input logic [15:0] b, input int hold);
        logic [3:0] nib;
        for (int d = 7; d >= 0; d--) begin
            nib = (d >= 4) ? a[(d-4)*4 +: 4] : b[d*4 +: 4];
            applyStimulus(~(8'd1 << d), glyphTab[nib], hold);
        end
    endtask

    task automatic checkpoint(input string tag);
        applyStimulus(8'hFF, 7'h7F, 6);
        checkOutput({tag, ".frames"}, 32'(fvCount), 32'(expFrames));
        checkOutput({tag, ".errs"}, 32'(errCount), 32'(expErrs));
        checkOutput({tag, ".NumberA"}, 32'(NumberA), 32'(expA));
        checkOutput({tag, ".NumberB"}, 32'(NumberB), 32'(expB));
        checkOutput({tag, ".stale"}, 32'(stale), 32'(expStale));
    endtask

    task automatic doReset();
        en_out = 8'hFF;
        out7 = 7'h7F;
        Reset = 1'b0;
        #2;
        checkOutput("rst.NumberA", 32'(NumberA), 32'h0);
        checkOutput("rst.NumberB", 32'(NumberB), 32'h0);
        checkOutput("rst.frame_valid", 32'(frame_valid), 32'h0);
        checkOutput("rst.seg_err", 32'(seg_err), 32'h0);
        checkOutput("rst.stale", 32'(stale), 32'h0);
        seenM = 8'h00;
        runVal = 15'h7FFF;
        runLen = 0;
        expA = 16'h0;
        expB = 16'h0;
        expStale = 1'b0;
        idleM = 0;
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b1;
    endtask

    // Pulse counters and the hold-between-frames check run every cycle outside reset.
    always @(negedge Clk) begin
        if (Reset) begin
            if (frame_valid) fvCount++;
            if (seg_err) errCount++;
            if (!frame_valid) begin
                checkOutput("holdA", 32'(NumberA), 32'(lastA));
                checkOutput("holdB", 32'(NumberB), 32'(lastB));
            end
        end
        lastA = NumberA;
        lastB = NumberB;
    end

    initial begin
        int lat;
        int kind;
        int len;
        int a;
        int b;
        logic [7:0] en;
        logic [6:0] seg;

        #1;
        doReset();
        applyStimulus(8'hFF, 7'h7F, 2);

        scanFrame(16'h1234, 16'hABCD, 40);
        checkpoint("scan1234");
        checkOutput("scan1234.A", 32'(NumberA), 32'h1234);
        checkOutput("scan1234.B", 32'(NumberB), 32'hABCD);
        checkOutput("scan1234.count", 32'(fvCount), 32'd1);

        for (int d = 7; d >= 4; d--) applyStimulus(~(8'd1 << d), glyphTab[d], 40);
        applyStimulus(8'hF7, glyphTab[3], S - 1);
        for (int d = 2; d >= 0; d--) applyStimulus(~(8'd1 << d), glyphTab[d], 40);
        checkpoint("ghost.short");
        checkOutput("ghost.noFrame", 32'(fvCount), 32'd1);
        applyStimulus(8'hF7, glyphTab[9], S);
        checkpoint("ghost.rescan");
        checkOutput("ghost.A", 32'(NumberA), 32'h7654);
        checkOutput("ghost.B", 32'(NumberB), 32'h9210);

        applyStimulus(8'hFC, glyphTab[5], 40);
        checkpoint("illegalSel");
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            applyStimulus(8'hFE, 7'h7F, 1);
            if (seg_err && lat < 0) lat = k;
        end
        checkOutput("errLatency", 32'(lat), 32'(S + 2));
        checkpoint("badGlyph");
        checkOutput("badGlyph.errs", 32'(errCount), 32'd1);

        for (int d = 7; d >= 3; d--) applyStimulus(~(8'd1 << d), glyphTab[1], 40);
        applyStimulus(8'hFF, 7'h7F, 6);
        doReset();
        checkOutput("midReset.A", 32'(NumberA), 32'h0);
        applyStimulus(8'hFF, 7'h7F, 2);
        scanFrame(16'hFFFF, 16'h0000, 40);
        checkpoint("midReset");
        checkOutput("midReset.A2", 32'(NumberA), 32'hFFFF);
        checkOutput("midReset.B2", 32'(NumberB), 32'h0000);

        for (int f = 0; f < 6; f++) begin
            a = $urandom_range(0, 65535);
            b = $urandom_range(0, 65535);
            case ($urandom_range(0, 2))
                0: len = S;
                1: len = S + 1;
                default: len = 40;
            endcase
            scanFrame(16'(a), 16'(b), len);
            checkpoint("randFrame");
        end

        for (int n = 0; n < 48; n++) begin
            kind = $urandom_range(0, 9);
            a = $urandom_range(0, 7);
            if (kind == 0) begin
                en = 8'hFF;
            end else if (kind == 1) begin
                b = (a + 1 + $urandom_range(0, 6)) % 8;
                en = ~((8'd1 << a) | (8'd1 << b));
            end else begin
                en = ~(8'd1 << a);
            end
            if ($urandom_range(0, 7) == 0) seg = 7'($urandom_range(0, 127));
            else seg = glyphTab[$urandom_range(0, 15)];
            case ($urandom_range(0, 5))
                0: len = S - 1;
                1: len = S;
                2: len = S + 1;
                3: len = 2;
                4: len = 40;
                default: len = $urandom_range(1, 50);
            endcase
            applyStimulus(en, seg, len);
            if (n % 8 == 7) checkpoint("randSeg");
        end

`ifdef SCAN_TIMEOUT_EN
        scanFrame(16'h0F0F, 16'h5A5A, 40);
        checkpoint("preTimeout");
        for (int d = 7; d >= 5; d--) applyStimulus(~(8'd1 << d), glyphTab[d], 40);
        applyStimulus(8'hFF, 7'h7F, T + 10);
        checkpoint("timeout");
        checkOutput("timeout.stale", 32'(stale), 32'h1);
        scanFrame(16'hC0DE, 16'h2468, 40);
        checkpoint("afterTimeout");
        checkOutput("afterTimeout.stale", 32'(stale), 32'h0);
        checkOutput("afterTimeout.A", 32'(NumberA), 32'hC0DE);
`else
        applyStimulus(8'hFF, 7'h7F, 200);
        checkpoint("noTimeout");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
